// File: rtl/spi_flash_pkg.sv
// Shared types and constants for the SPI flash read scheduler and the SpiFlash engine handshake.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package spi_flash_pkg;

    localparam int FLASH_ADDR_W = 32;
    localparam int FLASH_DATA_W = 8;

    // SpiFlash handshake: single-cycle read strobe in, single-cycle done pulse back
    localparam int FLASH_RD_PULSE_CYC   = 1;
    localparam int FLASH_DONE_PULSE_CYC = 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_HOLD
    } SCHED_STATE_T;

    function automatic logic [1:0] port_onehot(input logic port);
        return port ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; the last-granted port loses a tie.
// Latency: grant is combinational from req; history updates on accept.
// Backpressure: history holds until the grant is actually accepted.
module rr_arbiter2 (
    input  logic       iClk,
    input  logic       iRstN,
    input  logic [1:0] req,
    input  logic       accept,
    output logic       grant,
    output logic       grant_vld
);

    logic last_grant;

    always_comb begin
        grant_vld = |req;
        if (req == 2'b11) begin
            grant = ~last_grant;
        end else begin
            grant = req[1];
        end
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= grant;
        end
    end

endmodule

// File: rtl/spi_flash_read_sched.sv
// Round-robin burst read scheduler in front of the byte-wide SpiFlash engine.
// Latency: accept at T gives oFlashRd at T+1; each byte handshake gives the next oFlashRd 1 cycle later.
// Backpressure: oData/oDataValid hold until iDataReady of the owning port; a watchdog aborts a silent flash read.
module spi_flash_read_sched
    import spi_flash_pkg::*;
#(
    parameter int ADDR_W      = 24,
    parameter int LEN_W       = 8,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                    iClk,
    input  logic                    iRstN,
    input  logic [1:0]              iReqValid,
    output logic [1:0]              oReqReady,
    input  logic [ADDR_W-1:0]       iReqAddr0,
    input  logic [ADDR_W-1:0]       iReqAddr1,
    input  logic [LEN_W-1:0]        iReqLen0,
    input  logic [LEN_W-1:0]        iReqLen1,
    output logic [7:0]              oData,
    output logic [1:0]              oDataValid,
    input  logic [1:0]              iDataReady,
    output logic [1:0]              oDone,
    output logic                    oErr,
    output logic                    oFlashRd,
    output logic [FLASH_ADDR_W-1:0] oFlashAddr,
    input  logic [7:0]              iFlashData,
    input  logic                    iFlashDone,
    output logic                    oBusy
);

    localparam int WD_W = $clog2(TIMEOUT_CYC);

    SCHED_STATE_T            state, state_nxt;
    logic [ADDR_W-1:0]       cur_addr;
    logic [LEN_W-1:0]        rem;
    logic                    port;
    logic [WD_W-1:0]         wdog;
    logic [FLASH_DATA_W-1:0] data_q;
    logic [1:0]              data_vld_q;
    logic [1:0]              done_q;
    logic                    err_q;

    logic                    grant, grant_vld, accept;
    logic [ADDR_W-1:0]       sel_addr;
    logic [LEN_W-1:0]        sel_len;
    logic                    wd_expire;
    logic                    hs;

    rr_arbiter2 u_arb (
        .iClk      (iClk),
        .iRstN     (iRstN),
        .req       (iReqValid),
        .accept    (accept),
        .grant     (grant),
        .grant_vld (grant_vld)
    );

    assign sel_addr  = grant ? iReqAddr1 : iReqAddr0;
    assign sel_len   = grant ? iReqLen1  : iReqLen0;
    assign wd_expire = (wdog == WD_W'(TIMEOUT_CYC - 1));
    assign hs        = (state == S_HOLD) && iDataReady[port];

    always_comb begin
        state_nxt = state;
        oReqReady = 2'b00;
        accept    = 1'b0;
        case (state)
            S_IDLE: begin
                // grant always points at a valid port, so ready implies accept
                if (grant_vld) begin
                    oReqReady = port_onehot(grant);
                    accept    = 1'b1;
                    if (sel_len != '0) begin
                        state_nxt = S_ISSUE;
                    end
                end
            end
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT: begin
                if (iFlashDone) begin
                    state_nxt = S_HOLD;
                end else if (wd_expire) begin
                    state_nxt = S_IDLE;
                end
            end
            S_HOLD: begin
                if (hs) begin
                    state_nxt = (rem == LEN_W'(1)) ? S_IDLE : S_ISSUE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            cur_addr   <= '0;
            rem        <= '0;
            port       <= 1'b0;
            wdog       <= '0;
            data_q     <= '0;
            data_vld_q <= 2'b00;
            done_q     <= 2'b00;
            err_q      <= 1'b0;
        end else begin
            done_q <= 2'b00;
            err_q  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        cur_addr <= sel_addr;
                        rem      <= sel_len;
                        port     <= grant;
                        if (sel_len == '0) begin
                            done_q <= port_onehot(grant);
                        end
                    end
                end
                // watchdog counts cycles elapsed since the strobe
                S_ISSUE: wdog <= WD_W'(1);
                S_WAIT: begin
                    if (iFlashDone) begin
                        data_q     <= iFlashData;
                        data_vld_q <= port_onehot(port);
                    end else if (wd_expire) begin
                        done_q <= port_onehot(port);
                        err_q  <= 1'b1;
                    end else begin
                        wdog <= wdog + WD_W'(1);
                    end
                end
                S_HOLD: begin
                    if (hs) begin
                        data_vld_q <= 2'b00;
                        cur_addr   <= cur_addr + ADDR_W'(1);
                        rem        <= rem - LEN_W'(1);
                        if (rem == LEN_W'(1)) begin
                            done_q <= port_onehot(port);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign oData      = data_q;
    assign oDataValid = data_vld_q;
    assign oDone      = done_q;
    assign oErr       = err_q;
    assign oFlashRd   = (state == S_ISSUE);
    assign oFlashAddr = FLASH_ADDR_W'(cur_addr);
    assign oBusy      = (state != S_IDLE);

endmodule

// File: tb/tb_spi_flash_read_sched.sv
// Bench for spi_flash_read_sched: directed scenarios plus randomized bursts against a queue-based model.
// A forked flash responder answers each read with a byte derived from its address.
// The DUT is built with a 16-cycle watchdog so the timeout case stays short.
`timescale 1ns/1ps
module tb_spi_flash_read_sched;

    localparam int TMO = 16;

    logic        iClk = 1'b0;
    logic        iRstN;
    logic [1:0]  iReqValid, oReqReady;
    logic [23:0] iReqAddr0, iReqAddr1;
    logic [7:0]  iReqLen0, iReqLen1;
    logic [7:0]  oData;
    logic [1:0]  oDataValid, iDataReady, oDone;
    logic        oErr, oFlashRd, iFlashDone, oBusy;
    logic [31:0] oFlashAddr;
    logic [7:0]  iFlashData;

    always #5 iClk = ~iClk;

    spi_flash_read_sched #(.ADDR_W(24), .LEN_W(8), .TIMEOUT_CYC(TMO)) dut (
        .iClk(iClk), .iRstN(iRstN), .iReqValid(iReqValid), .oReqReady(oReqReady),
        .iReqAddr0(iReqAddr0), .iReqAddr1(iReqAddr1), .iReqLen0(iReqLen0), .iReqLen1(iReqLen1),
        .oData(oData), .oDataValid(oDataValid), .iDataReady(iDataReady), .oDone(oDone), .oErr(oErr),
        .oFlashRd(oFlashRd), .oFlashAddr(oFlashAddr), .iFlashData(iFlashData), .iFlashDone(iFlashDone),
        .oBusy(oBusy)
    );

    int n_chk = 0, n_pass = 0;
    int cyc = 0;
    always @(posedge iClk) cyc <= cyc + 1;

    // observed event logs
    int          rd_cyc_q[$], bt_cyc_q[$], bt_port_q[$], dn_cyc_q[$], dn_port_q[$], acc_cyc_q[$], acc_port_q[$];
    logic [31:0] rd_addr_q[$];
    logic [7:0]  bt_dat_q[$];
    logic        dn_err_q[$];
    int          multi_vld = 0;

    // expected event logs
    logic [31:0] exp_addr_q[$];
    logic [7:0]  exp_dat_q[$];
    int          exp_bport_q[$], exp_dport_q[$], exp_acc_q[$];
    logic        exp_derr_q[$];
    int          ref_last = 1;

    int flash_dly = 10;
    bit flash_on = 1'b1, flash_rand = 1'b0, rand_rdy = 1'b0;
    int rst_gen = 0;

    always @(negedge iClk) begin
        if (iRstN) begin
            if (oFlashRd) begin rd_cyc_q.push_back(cyc); rd_addr_q.push_back(oFlashAddr); end
            for (int p = 0; p < 2; p++) begin
                if (oDataValid[p] && iDataReady[p]) begin
                    bt_cyc_q.push_back(cyc); bt_port_q.push_back(p); bt_dat_q.push_back(oData);
                end
                if (oDone[p]) begin dn_cyc_q.push_back(cyc); dn_port_q.push_back(p); dn_err_q.push_back(oErr); end
                if (iReqValid[p] && oReqReady[p]) begin acc_cyc_q.push_back(cyc); acc_port_q.push_back(p); end
            end
            if (oDataValid == 2'b11 || oDone == 2'b11) multi_vld++;
        end
    end

    function automatic logic [7:0] flash_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'h5A;
    endfunction

    task automatic clear_logs();
        rd_cyc_q.delete(); rd_addr_q.delete(); bt_cyc_q.delete(); bt_port_q.delete(); bt_dat_q.delete();
        dn_cyc_q.delete(); dn_port_q.delete(); dn_err_q.delete(); acc_cyc_q.delete(); acc_port_q.delete();
        exp_addr_q.delete(); exp_dat_q.delete(); exp_bport_q.delete(); exp_dport_q.delete();
        exp_derr_q.delete(); exp_acc_q.delete();
        multi_vld = 0;
    endtask

    // Reference: a burst reads addr, addr+1, ... (mod 2^24) and ends with one error-free done.
    task automatic model_burst(input int p, input logic [23:0] a, input int len);
        logic [23:0] x;
        exp_acc_q.push_back(p);
        for (int i = 0; i < len; i++) begin
            x = a + 24'(i);
            exp_addr_q.push_back({8'h00, x});
            exp_dat_q.push_back(flash_byte({8'h00, x}));
            exp_bport_q.push_back(p);
        end
        exp_dport_q.push_back(p);
        exp_derr_q.push_back(1'b0);
    endtask

    // Reference arbitration: lone requester wins; on a tie the port that did not win last time goes first.
    task automatic model_round(input logic [1:0] mask, input logic [23:0] a0, a1, input int l0, l1);
        int first;
        if (mask == 2'b11) begin
            first = (ref_last == 0) ? 1 : 0;
            model_burst(first, first ? a1 : a0, first ? l1 : l0);
            model_burst(1 - first, first ? a0 : a1, first ? l0 : l1);
            ref_last = 1 - first;
        end else begin
            first = mask[1] ? 1 : 0;
            model_burst(first, first ? a1 : a0, first ? l1 : l0);
            ref_last = first;
        end
    endtask

    task automatic flash_responder();
        int g, d;
        logic [31:0] a;
        forever begin
            @(negedge iClk);
            if (iRstN && oFlashRd && flash_on) begin
                g = rst_gen; a = oFlashAddr;
                d = flash_rand ? int'($urandom_range(1, 12)) : flash_dly;
                repeat (d) @(posedge iClk);
                #1;
                if (g == rst_gen) begin
                    iFlashDone = 1'b1; iFlashData = flash_byte(a);
                    @(posedge iClk); #1;
                    iFlashDone = 1'b0; iFlashData = 8'($urandom);
                end
            end
        end
    endtask

    task automatic present(input logic [1:0] mask, input logic [23:0] a0, a1,
                           input logic [7:0] l0, l1, output bit ok);
        logic [1:0] acc;
        @(posedge iClk); #1;
        iReqAddr0 = a0; iReqAddr1 = a1; iReqLen0 = l0; iReqLen1 = l1; iReqValid = mask;
        ok = 1'b1;
        for (int t = 0; iReqValid != 2'b00; t++) begin
            if (t > 3000) begin ok = 1'b0; iReqValid = 2'b00; break; end
            @(negedge iClk);
            acc = iReqValid & oReqReady;
            @(posedge iClk); #1;
            iReqValid = iReqValid & ~acc;
        end
    endtask

    task automatic wait_done(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < budget; t++) begin
            @(negedge iClk);
            if (dn_port_q.size() >= n) begin ok = 1'b1; break; end
        end
        repeat (3) @(negedge iClk);
    endtask

    task automatic test_reset();
        iRstN = 1'b0;
        repeat (2) @(negedge iClk);
        n_chk++; if ({oReqReady, oDataValid, oDone, oErr, oFlashRd, oBusy} !== 9'h0)
            $display("FAIL reset_ctrl got %b want 0", {oReqReady, oDataValid, oDone, oErr, oFlashRd, oBusy}); else n_pass++;
        n_chk++; if (oData !== 8'h00) $display("FAIL reset_data got %h want 00", oData); else n_pass++;
        n_chk++; if (oFlashAddr !== 32'h0) $display("FAIL reset_addr got %h want 0", oFlashAddr); else n_pass++;
        @(posedge iClk); #1 iRstN = 1'b1; ref_last = 1;
        @(negedge iClk);
        n_chk++; if ({oBusy, oReqReady} !== 3'b000) $display("FAIL idle_after_reset got %b want 000", {oBusy, oReqReady}); else n_pass++;
    endtask

    task automatic test_single_burst();
        bit ok;
        logic [31:0] want;
        clear_logs(); flash_dly = 10; iDataReady = 2'b11;
        model_round(2'b01, 24'h00000F, 24'h0, 3, 0);
        present(2'b01, 24'h00000F, 24'h0, 8'd3, 8'd0, ok);
        if (ok) wait_done(1, 400, ok);
        n_chk++; if (!ok) $display("FAIL single_done got none want oDone[0]"); else n_pass++;
        n_chk++; if (rd_addr_q.size() !== 3) $display("FAIL single_rd_count got %0d want 3", rd_addr_q.size()); else n_pass++;
        for (int i = 0; i < 3 && i < rd_addr_q.size(); i++) begin
            want = 32'h0F + 32'(i);
            n_chk++; if (rd_addr_q[i] !== want) $display("FAIL single_rd_addr%0d got %h want %h", i, rd_addr_q[i], want); else n_pass++;
        end
        n_chk++; if (bt_dat_q.size() !== 3) $display("FAIL single_beats got %0d want 3", bt_dat_q.size()); else n_pass++;
        for (int i = 0; i < 3 && i < bt_dat_q.size(); i++) begin
            n_chk++; if (bt_dat_q[i] !== exp_dat_q[i] || bt_port_q[i] !== 0)
                $display("FAIL single_beat%0d got %h/p%0d want %h/p0", i, bt_dat_q[i], bt_port_q[i], exp_dat_q[i]); else n_pass++;
        end
        if (rd_cyc_q.size() == 3 && acc_cyc_q.size() == 1 && bt_cyc_q.size() == 3 && dn_cyc_q.size() == 1) begin
            n_chk++; if (rd_cyc_q[0] !== acc_cyc_q[0] + 1) $display("FAIL issue_latency got %0d want %0d", rd_cyc_q[0], acc_cyc_q[0] + 1); else n_pass++;
            n_chk++; if (rd_cyc_q[1] !== bt_cyc_q[0] + 1) $display("FAIL next_rd_latency got %0d want %0d", rd_cyc_q[1], bt_cyc_q[0] + 1); else n_pass++;
            n_chk++; if (bt_cyc_q[0] !== rd_cyc_q[0] + 11) $display("FAIL data_latency got %0d want %0d", bt_cyc_q[0], rd_cyc_q[0] + 11); else n_pass++;
            n_chk++; if (dn_cyc_q[0] !== bt_cyc_q[2] + 1) $display("FAIL done_latency got %0d want %0d", dn_cyc_q[0], bt_cyc_q[2] + 1); else n_pass++;
            n_chk++; if (dn_port_q[0] !== 0 || dn_err_q[0] !== 1'b0) $display("FAIL single_done_port got p%0d err%b want p0 err0", dn_port_q[0], dn_err_q[0]); else n_pass++;
        end else begin
            n_chk++; $display("FAIL single_event_counts got rd%0d acc%0d bt%0d dn%0d want 3/1/3/1",
                              rd_cyc_q.size(), acc_cyc_q.size(), bt_cyc_q.size(), dn_cyc_q.size());
        end
    endtask

    task automatic test_both_valid();
        bit ok;
        logic [23:0] a0, a1;
        iRstN = 1'b0; rst_gen++; repeat (2) @(posedge iClk); #1 iRstN = 1'b1; ref_last = 1;
        clear_logs(); iDataReady = 2'b11; flash_dly = 4;
        a0 = 24'($urandom); a1 = 24'($urandom);
        model_round(2'b11, a0, a1, 1, 1);
        present(2'b11, a0, a1, 8'd1, 8'd1, ok);
        if (ok) wait_done(2, 400, ok);
        n_chk++; if (!ok) $display("FAIL both_done got %0d dones want 2", dn_port_q.size()); else n_pass++;
        if (acc_port_q.size() == 2 && rd_addr_q.size() == 2 && dn_port_q.size() == 2) begin
            n_chk++; if (acc_port_q[0] !== 0 || acc_port_q[1] !== 1) $display("FAIL both_order got %0d,%0d want 0,1", acc_port_q[0], acc_port_q[1]); else n_pass++;
            n_chk++; if (rd_addr_q[0] !== {8'h0, a0} || rd_addr_q[1] !== {8'h0, a1})
                $display("FAIL both_addrs got %h,%h want %h,%h", rd_addr_q[0], rd_addr_q[1], a0, a1); else n_pass++;
            n_chk++; if (dn_port_q[0] !== 0 || dn_port_q[1] !== 1 || dn_cyc_q[0] >= dn_cyc_q[1])
                $display("FAIL both_done_order got p%0d@%0d,p%0d@%0d want p0 first", dn_port_q[0], dn_cyc_q[0], dn_port_q[1], dn_cyc_q[1]); else n_pass++;
        end else begin
            n_chk++; $display("FAIL both_counts got acc%0d rd%0d dn%0d want 2/2/2", acc_port_q.size(), rd_addr_q.size(), dn_port_q.size());
        end
    endtask

    task automatic test_wrap();
        bit ok;
        clear_logs(); iDataReady = 2'b11; flash_dly = 2;
        model_round(2'b10, 24'h0, 24'hFFFFFF, 0, 2);
        present(2'b10, 24'h0, 24'hFFFFFF, 8'd0, 8'd2, ok);
        if (ok) wait_done(1, 200, ok);
        n_chk++; if (!ok) $display("FAIL wrap_done got none want oDone[1]"); else n_pass++;
        if (rd_addr_q.size() == 2 && bt_dat_q.size() == 2) begin
            n_chk++; if (rd_addr_q[0] !== 32'h00FFFFFF) $display("FAIL wrap_addr0 got %h want 00ffffff", rd_addr_q[0]); else n_pass++;
            n_chk++; if (rd_addr_q[1] !== 32'h00000000) $display("FAIL wrap_addr1 got %h want 00000000", rd_addr_q[1]); else n_pass++;
            n_chk++; if (bt_dat_q[1] !== exp_dat_q[1] || bt_port_q[1] !== 1) $display("FAIL wrap_data got %h/p%0d want %h/p1", bt_dat_q[1], bt_port_q[1], exp_dat_q[1]); else n_pass++;
        end else begin
            n_chk++; $display("FAIL wrap_counts got rd%0d bt%0d want 2/2", rd_addr_q.size(), bt_dat_q.size());
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int bad;
        logic [7:0] d;
        logic [23:0] a;
        clear_logs(); iDataReady = 2'b10; flash_dly = 3; a = 24'($urandom);
        model_round(2'b01, a, 24'h0, 2, 0);
        present(2'b01, a, 24'h0, 8'd2, 8'd0, ok);
        ok = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge iClk);
            if (oDataValid[0]) begin ok = 1'b1; break; end
        end
        n_chk++; if (!ok) $display("FAIL bp_first_byte got none want oDataValid[0]"); else n_pass++;
        d = oData; bad = 0;
        repeat (50) begin
            @(negedge iClk);
            if (oDataValid !== 2'b01 || oData !== d || oFlashRd !== 1'b0) bad++;
        end
        n_chk++; if (bad !== 0) $display("FAIL bp_hold got %0d unstable cycles want 0", bad); else n_pass++;
        n_chk++; if (d !== exp_dat_q[0]) $display("FAIL bp_data got %h want %h", d, exp_dat_q[0]); else n_pass++;
        n_chk++; if (rd_cyc_q.size() !== 1) $display("FAIL bp_no_early_rd got %0d reads want 1", rd_cyc_q.size()); else n_pass++;
        @(posedge iClk); #1 iDataReady = 2'b01;
        wait_done(1, 200, ok);
        n_chk++; if (!ok) $display("FAIL bp_done got none want oDone[0]"); else n_pass++;
        if (rd_cyc_q.size() == 2 && bt_cyc_q.size() == 2) begin
            n_chk++; if (rd_cyc_q[1] !== bt_cyc_q[0] + 1) $display("FAIL bp_rd_after_hs got %0d want %0d", rd_cyc_q[1], bt_cyc_q[0] + 1); else n_pass++;
            n_chk++; if (rd_addr_q[1] !== exp_addr_q[1]) $display("FAIL bp_addr1 got %h want %h", rd_addr_q[1], exp_addr_q[1]); else n_pass++;
        end else begin
            n_chk++; $display("FAIL bp_counts got rd%0d bt%0d want 2/2", rd_cyc_q.size(), bt_cyc_q.size());
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int bad;
        clear_logs(); flash_on = 1'b0; iDataReady = 2'b11;
        model_round(2'b01, 24'h000100, 24'h0, 4, 0);
        present(2'b01, 24'h000100, 24'h0, 8'd4, 8'd0, ok);
        if (ok) wait_done(1, 200, ok);
        n_chk++; if (!ok) $display("FAIL tmo_done got none want oDone[0]"); else n_pass++;
        if (dn_cyc_q.size() == 1 && rd_cyc_q.size() == 1) begin
            n_chk++; if (dn_cyc_q[0] !== rd_cyc_q[0] + TMO) $display("FAIL tmo_cycle got %0d want %0d", dn_cyc_q[0], rd_cyc_q[0] + TMO); else n_pass++;
            n_chk++; if (dn_err_q[0] !== 1'b1 || dn_port_q[0] !== 0) $display("FAIL tmo_err got p%0d err%b want p0 err1", dn_port_q[0], dn_err_q[0]); else n_pass++;
        end else begin
            n_chk++; $display("FAIL tmo_counts got dn%0d rd%0d want 1/1", dn_cyc_q.size(), rd_cyc_q.size());
        end
        n_chk++; if (oBusy !== 1'b0) $display("FAIL tmo_idle got busy=%b want 0", oBusy); else n_pass++;
        @(posedge iClk); #1 iFlashDone = 1'b1; iFlashData = 8'hA5;
        @(posedge iClk); #1 iFlashDone = 1'b0;
        bad = 0;
        repeat (6) begin @(negedge iClk); if (oDataValid !== 2'b00 || oDone !== 2'b00 || oBusy !== 1'b0) bad++; end
        n_chk++; if (bad !== 0 || rd_cyc_q.size() !== 1) $display("FAIL tmo_late_done got %0d bad cycles, %0d reads want 0, 1", bad, rd_cyc_q.size()); else n_pass++;
        flash_on = 1'b1;
    endtask

    task automatic test_random();
        bit ok;
        logic [1:0] m;
        logic [23:0] a0, a1;
        logic [7:0] l0, l1;
        clear_logs(); flash_rand = 1'b1; rand_rdy = 1'b1;
        fork
            begin
                while (rand_rdy) begin @(posedge iClk); #1; iDataReady = 2'($urandom); end
            end
        join_none
        for (int r = 0; r < 25; r++) begin
            m  = 2'($urandom_range(1, 3));
            a0 = ($urandom_range(0, 3) == 0) ? 24'hFFFFFF - 24'($urandom_range(0, 3)) : 24'($urandom);
            a1 = 24'($urandom);
            l0 = 8'($urandom_range(0, 5)); l1 = 8'($urandom_range(0, 5));
            model_round(m, a0, a1, int'(l0), int'(l1));
            present(m, a0, a1, l0, l1, ok);
            if (!ok) break;
        end
        if (ok) wait_done(exp_dport_q.size(), 20000, ok);
        rand_rdy = 1'b0; flash_rand = 1'b0;
        repeat (3) @(posedge iClk);
        iDataReady = 2'b00;
        n_chk++; if (!ok) $display("FAIL rnd_done got %0d dones want %0d", dn_port_q.size(), exp_dport_q.size()); else n_pass++;
        n_chk++; if (acc_port_q.size() !== exp_acc_q.size() || rd_addr_q.size() !== exp_addr_q.size()
                     || bt_dat_q.size() !== exp_dat_q.size() || dn_port_q.size() !== exp_dport_q.size())
            $display("FAIL rnd_counts got acc%0d rd%0d bt%0d dn%0d want %0d/%0d/%0d/%0d", acc_port_q.size(), rd_addr_q.size(),
                     bt_dat_q.size(), dn_port_q.size(), exp_acc_q.size(), exp_addr_q.size(), exp_dat_q.size(), exp_dport_q.size());
        else n_pass++;
        for (int i = 0; i < exp_acc_q.size() && i < acc_port_q.size(); i++) begin
            n_chk++; if (acc_port_q[i] !== exp_acc_q[i]) $display("FAIL rnd_grant%0d got p%0d want p%0d", i, acc_port_q[i], exp_acc_q[i]); else n_pass++;
        end
        for (int i = 0; i < exp_addr_q.size() && i < rd_addr_q.size(); i++) begin
            n_chk++; if (rd_addr_q[i] !== exp_addr_q[i]) $display("FAIL rnd_addr%0d got %h want %h", i, rd_addr_q[i], exp_addr_q[i]); else n_pass++;
        end
        for (int i = 0; i < exp_dat_q.size() && i < bt_dat_q.size(); i++) begin
            n_chk++; if (bt_dat_q[i] !== exp_dat_q[i] || bt_port_q[i] !== exp_bport_q[i])
                $display("FAIL rnd_beat%0d got %h/p%0d want %h/p%0d", i, bt_dat_q[i], bt_port_q[i], exp_dat_q[i], exp_bport_q[i]); else n_pass++;
        end
        for (int i = 0; i < exp_dport_q.size() && i < dn_port_q.size(); i++) begin
            n_chk++; if (dn_port_q[i] !== exp_dport_q[i] || dn_err_q[i] !== exp_derr_q[i])
                $display("FAIL rnd_done%0d got p%0d err%b want p%0d err%b", i, dn_port_q[i], dn_err_q[i], exp_dport_q[i], exp_derr_q[i]); else n_pass++;
        end
        n_chk++; if (multi_vld !== 0) $display("FAIL rnd_onehot got %0d multi-port cycles want 0", multi_vld); else n_pass++;
    endtask

    task automatic test_reset_in_hold();
        bit ok;
        clear_logs(); iDataReady = 2'b00; flash_dly = 3;
        model_round(2'b01, 24'h000040, 24'h0, 2, 0);
        present(2'b01, 24'h000040, 24'h0, 8'd2, 8'd0, ok);
        ok = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge iClk);
            if (oDataValid[0]) begin ok = 1'b1; break; end
        end
        n_chk++; if (!ok) $display("FAIL rsthold_reach got none want oDataValid[0]"); else n_pass++;
        #2 iRstN = 1'b0; rst_gen++;
        #1;
        n_chk++; if ({oReqReady, oDataValid, oDone, oErr, oFlashRd, oBusy, oData, oFlashAddr} !== 49'h0)
            $display("FAIL rsthold_async got dv=%b busy=%b data=%h addr=%h want all 0", oDataValid, oBusy, oData, oFlashAddr); else n_pass++;
        @(posedge iClk); #1 iRstN = 1'b1; ref_last = 1;
        clear_logs();
        model_round(2'b10, 24'h0, 24'h123456, 0, 0);
        present(2'b10, 24'h0, 24'h123456, 8'd0, 8'd0, ok);
        if (ok) wait_done(1, 50, ok);
        repeat (5) @(negedge iClk);
        n_chk++; if (!ok) $display("FAIL rsthold_len0_done got none want oDone[1]"); else n_pass++;
        if (dn_cyc_q.size() == 1 && acc_cyc_q.size() == 1) begin
            n_chk++; if (dn_cyc_q[0] !== acc_cyc_q[0] + 1 || dn_port_q[0] !== 1 || dn_err_q[0] !== 1'b0)
                $display("FAIL rsthold_len0 got p%0d@%0d err%b want p1@%0d err0", dn_port_q[0], dn_cyc_q[0], dn_err_q[0], acc_cyc_q[0] + 1); else n_pass++;
        end else begin
            n_chk++; $display("FAIL rsthold_counts got dn%0d acc%0d want 1/1", dn_cyc_q.size(), acc_cyc_q.size());
        end
        n_chk++; if (rd_cyc_q.size() !== 0) $display("FAIL rsthold_no_rd got %0d reads want 0", rd_cyc_q.size()); else n_pass++;
    endtask

    initial begin
        iRstN = 1'b0; iReqValid = 2'b00; iReqAddr0 = '0; iReqAddr1 = '0; iReqLen0 = '0; iReqLen1 = '0;
        iDataReady = 2'b00; iFlashDone = 1'b0; iFlashData = 8'h00;
        fork
            flash_responder();
        join_none
        test_reset();
        test_single_burst();
        test_both_valid();
        test_wrap();
        test_backpressure();
        test_timeout();
        test_random();
        test_reset_in_hold();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL global_timeout got no finish want finish within 80000 cycles");
        $fatal(1, "simulation time limit");
    end

endmodule
